counter_stream_checker: RTL and testbench
=========================================

Name: counter_stream_checker

Overview:
- Checker at the consuming end of the 8-bit counter interface (enable, reset, counter value).
- Samples the counter output every clock and predicts the next value from the sampled enable and counter-reset.
- Flags every deviation, counts errors and wrap events, and reports lock status.
- Instantiated alongside counter blocks in benches and in on-chip self-test paths.

Parameters:
- WIDTH, 8, width of the monitored counter value.
- ERR_WIDTH, 16, width of the saturating error counter.
- WRAP_WIDTH, 16, width of the saturating wrap counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset of the checker.
- clear  input  1  synchronous clear: zeroes the statistics and returns the FSM to SYNC.
- dut_enable  input  1  enable as seen by the monitored counter.
- dut_reset  input  1  active-high reset as seen by the monitored counter.
- counter  input  WIDTH  monitored counter value.
- locked  output  1  high while the FSM is in TRACK.
- error  output  1  one-cycle pulse on a mismatch.
- wrap  output  1  one-cycle pulse on a legal MAX->0 increment.
- error_count  output  ERR_WIDTH  number of mismatches, saturating.
- wrap_count  output  WRAP_WIDTH  number of legal wraps, saturating.
- expected  output  WIDTH  registered prediction for the next sample.

Behaviour:
- Sample k is the value of (dut_reset, dut_enable, counter) captured at rising edge k.
- Prediction for sample k+1, width-truncated modulo 2^WIDTH:
  - if r_k = 1: 0 (reset has priority over enable);
  - else if e_k = 1: c_k + 1;
  - else: c_k.
- FSM states:
  - SYNC: no valid prediction yet. On the next edge, capture the prediction from the current sample, move to TRACK, perform no comparison, and assert neither error nor wrap.
  - TRACK: every edge compares counter against expected.
    - On mismatch: error = 1 for exactly the cycle after that edge, and error_count increments.
    - The prediction is always recomputed from the observed sample, so one glitch yields one error, not a stream of errors. The FSM stays in TRACK.
- Wrap: in TRACK, sample k+1 has c = 0, and sample k had c = 2^WIDTH-1, e = 1, r = 0. When this holds and the sample matches, wrap = 1 for one cycle and wrap_count increments. An erroneous 0 never counts as a wrap.
- A DUT reset (r_k = 1) predicting 0 is legal. It is not a wrap and not an error when the next sample is 0.
- Saturation: error_count and wrap_count hold at all-ones and never roll over.
- clear: synchronous, highest priority after reset. On that edge:
  - error_count, wrap_count, error, wrap and expected go to 0;
  - the FSM goes to SYNC and the sample on that edge is ignored.
- Asynchronous reset (reset = 0): immediately, independent of clock:
  - FSM to SYNC; locked = 0, error = 0, wrap = 0, error_count = 0, wrap_count = 0, expected = 0.
  - Deassertion is synchronized by the integrator. The first edge after release behaves as SYNC.
- Latency: error, wrap and the counters reflect sample k+1 starting immediately after edge k+1. locked rises after the first edge following reset or clear.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Basic increment: release reset, then dut_reset = 1 for 1 cycle with counter = 0, then dut_enable = 1 with counter driven 0,1,2,...,299 mod 256 -> locked = 1 from the second edge; error never set; exactly one wrap pulse after the 255->0 step; wrap_count = 1; error_count = 0.
- Hold: dut_enable = 0 for 10 cycles with counter held at 0x42 -> no error; expected = 0x42 throughout.
- Single glitch: while incrementing, drive counter = 0x10, 0x11, 0x55, 0x56, 0x57 -> exactly one error pulse (at the 0x55 sample); error_count = 1; 0x56 and 0x57 are accepted.
- DUT reset mid-run: counter at 0x80 with dut_enable = 1, pulse dut_reset = 1 for one sample, then drive counter = 0 -> no error, no wrap. Driving 0x81 instead -> one error.
- Saturation: with ERR_WIDTH = 4, inject 20 mismatches -> error_count stops at 15 and error still pulses each time.
- Reset and clear: assert reset mid-stream -> all outputs 0 immediately, asynchronously. Release, then pulse clear while tracking -> counters return to 0, locked drops for one cycle, and no error is raised on the first sample after clear.

Source files
------------

// File: rtl/counter_stream_checker.sv
// Consumer-side checker for an up-counter stream: predicts each sample from the previous one,
// flags mismatches, counts errors and legal wraps, and reports when it is tracking.
module counter_stream_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ERR_WIDTH  = 16,
  parameter int unsigned WRAP_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  dut_enable_i,
  input  logic                  dut_reset_i,
  input  logic [WIDTH-1:0]      counter_i,
  output logic                  locked_o,
  output logic                  error_o,
  output logic                  wrap_o,
  output logic [ERR_WIDTH-1:0]  error_count_o,
  output logic [WRAP_WIDTH-1:0] wrap_count_o,
  output logic [WIDTH-1:0]      expected_o
);

  typedef enum logic [0:0] {StSync, StTrack} state_e;

  localparam logic [WIDTH-1:0]      CntMax  = '1;
  localparam logic [ERR_WIDTH-1:0]  ErrMax  = '1;
  localparam logic [WRAP_WIDTH-1:0] WrapMax = '1;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      expected_q, expected_d;
  logic                  wrap_cand_q, wrap_cand_d;
  logic                  error_q, error_d;
  logic                  wrap_q, wrap_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [WRAP_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [WIDTH-1:0]      prediction;
  logic                  mismatch;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any sample outside of clear yields a prediction, so SYNC lasts one edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync:  state_d = clear_i ? StSync : StTrack;
      StTrack: state_d = clear_i ? StSync : StTrack;
      default: state_d = StSync;
    endcase
  end

  // FSM output.
  always_comb begin
    locked_o = (state_q == StTrack);
  end

  always_comb begin
    if (dut_reset_i) begin
      prediction = '0;
    end else if (dut_enable_i) begin
      prediction = counter_i + WIDTH'(1);
    end else begin
      prediction = counter_i;
    end
  end

  assign mismatch = (counter_i != expected_q);

  always_comb begin
    expected_d  = prediction;
    // Remembers that this sample was a legal MAX->0 step in the making.
    wrap_cand_d = (counter_i == CntMax) && dut_enable_i && !dut_reset_i;
    error_d     = 1'b0;
    wrap_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    if (clear_i) begin
      expected_d  = '0;
      wrap_cand_d = 1'b0;
      err_cnt_d   = '0;
      wrap_cnt_d  = '0;
    end else if (state_q == StTrack) begin
      error_d = mismatch;
      wrap_d  = !mismatch && wrap_cand_q;
      if (mismatch && (err_cnt_q != ErrMax)) begin
        err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
      end
      if (wrap_d && (wrap_cnt_q != WrapMax)) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      expected_q  <= '0;
      wrap_cand_q <= 1'b0;
      error_q     <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      expected_q  <= expected_d;
      wrap_cand_q <= wrap_cand_d;
      error_q     <= error_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign error_o       = error_q;
  assign wrap_o        = wrap_q;
  assign error_count_o = err_cnt_q;
  assign wrap_count_o  = wrap_cnt_q;
  assign expected_o    = expected_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Directed bench for counter_stream_checker: a sample-level reference model checked every cycle,
// plus hand-computed expectations at the end of each scenario.
module tb_counter_stream_checker;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ERR_WIDTH  = 4;
  localparam int unsigned WRAP_WIDTH = 16;
  localparam int          ErrSat     = 15;
  localparam int          WrapSat    = 65535;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  clear_i;
  logic                  dut_enable_i;
  logic                  dut_reset_i;
  logic [WIDTH-1:0]      counter_i;
  logic                  locked_o;
  logic                  error_o;
  logic                  wrap_o;
  logic [ERR_WIDTH-1:0]  error_count_o;
  logic [WRAP_WIDTH-1:0] wrap_count_o;
  logic [WIDTH-1:0]      expected_o;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int wrap_pulses = 0;

  counter_stream_checker #(
    .WIDTH     (WIDTH),
    .ERR_WIDTH (ERR_WIDTH),
    .WRAP_WIDTH(WRAP_WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .dut_enable_i (dut_enable_i),
    .dut_reset_i  (dut_reset_i),
    .counter_i    (counter_i),
    .locked_o     (locked_o),
    .error_o      (error_o),
    .wrap_o       (wrap_o),
    .error_count_o(error_count_o),
    .wrap_count_o (wrap_count_o),
    .expected_o   (expected_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference model: works on whole samples; the previous sample decides legality of a wrap.
  bit have_pred = 0;
  int m_pred = 0, m_err = 0, m_wrap = 0, m_ec = 0, m_wc = 0;
  int p_c = 0, p_e = 0, p_r = 0;

  initial begin
    int s_c, s_e, s_r;
    forever begin
      @(posedge clk_i);
      s_c = int'(counter_i);
      s_e = int'(dut_enable_i);
      s_r = int'(dut_reset_i);
      if (!rst_ni || clear_i) begin
        have_pred = 0;
        m_pred = 0; m_err = 0; m_wrap = 0; m_ec = 0; m_wc = 0;
      end else begin
        if (have_pred) begin
          m_err  = (s_c != m_pred) ? 1 : 0;
          m_wrap = (m_err == 0 && p_c == 255 && p_e == 1 && p_r == 0) ? 1 : 0;
          if (m_err == 1 && m_ec < ErrSat) m_ec++;
          if (m_wrap == 1 && m_wc < WrapSat) m_wc++;
        end else begin
          m_err = 0;
          m_wrap = 0;
        end
        m_pred = (s_r == 1) ? 0 : (s_e == 1) ? (s_c + 1) % 256 : s_c;
        p_c = s_c; p_e = s_e; p_r = s_r;
        have_pred = 1;
      end
      #1;
      chk("locked", int'(locked_o), have_pred ? 1 : 0);
      chk("error", int'(error_o), m_err);
      chk("wrap", int'(wrap_o), m_wrap);
      chk("error_count", int'(error_count_o), m_ec);
      chk("wrap_count", int'(wrap_count_o), m_wc);
      chk("expected", int'(expected_o), m_pred);
      if (error_o) err_pulses++;
      if (wrap_o) wrap_pulses++;
    end
  end

  // Inputs change on the falling edge and are sampled on the next rising edge.
  task automatic drive(input bit r, input bit e, input int c);
    dut_reset_i  = r;
    dut_enable_i = e;
    counter_i    = WIDTH'(c);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0;
    dut_enable_i = 1'b0; dut_reset_i = 1'b0; counter_i = '0;
    #1;
    chk("por_locked", int'(locked_o), 0);
    chk("por_expected", int'(expected_o), 0);
    chk("por_error_count", int'(error_count_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic increment with one wrap.
    err_pulses = 0; wrap_pulses = 0;
    drive(1, 0, 0);
    chk("lock_after_first_edge", int'(locked_o), 1);
    for (int i = 0; i < 300; i++) drive(0, 1, i % 256);
    chk("basic_err_pulses", err_pulses, 0);
    chk("basic_wrap_pulses", wrap_pulses, 1);
    chk("basic_wrap_count", int'(wrap_count_o), 1);
    chk("basic_error_count", int'(error_count_o), 0);
    chk("basic_expected", int'(expected_o), 44);

    // Hold at 0x42.
    for (int i = 44; i <= 'h41; i++) drive(0, 1, i);
    err_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 'h42);
      chk("hold_expected", int'(expected_o), 'h42);
    end
    chk("hold_err_pulses", err_pulses, 0);

    // Clear while tracking, then a single glitch.
    clear_i = 1'b1;
    drive(0, 1, 'h99);
    clear_i = 1'b0;
    chk("clear_locked", int'(locked_o), 0);
    chk("clear_wrap_count", int'(wrap_count_o), 0);
    chk("clear_expected", int'(expected_o), 0);
    err_pulses = 0;
    drive(0, 1, 'h0f);
    chk("post_clear_locked", int'(locked_o), 1);
    chk("post_clear_error", int'(error_o), 0);
    drive(0, 1, 'h10);
    drive(0, 1, 'h11);
    drive(0, 1, 'h55);
    chk("glitch_error", int'(error_o), 1);
    drive(0, 1, 'h56);
    drive(0, 1, 'h57);
    chk("glitch_err_pulses", err_pulses, 1);
    chk("glitch_error_count", int'(error_count_o), 1);

    // DUT reset mid-run: legal zero, then an illegal 0x81.
    for (int i = 'h58; i < 'h80; i++) drive(0, 1, i);
    err_pulses = 0; wrap_pulses = 0;
    drive(1, 1, 'h80);
    drive(0, 1, 0);
    chk("dutrst_zero_error", int'(error_o), 0);
    chk("dutrst_zero_wrap", int'(wrap_o), 0);
    for (int i = 1; i < 'h80; i++) drive(0, 1, i);
    drive(1, 1, 'h80);
    drive(0, 1, 'h81);
    chk("dutrst_81_error", int'(error_o), 1);
    chk("dutrst_err_pulses", err_pulses, 1);
    chk("dutrst_wrap_pulses", wrap_pulses, 0);
    chk("dutrst_error_count", int'(error_count_o), 2);

    // Saturation: 20 mismatches with the count held.
    err_pulses = 0;
    for (int i = 0; i < 20; i++) drive(0, 0, (i % 2 == 0) ? 'haa : 'h55);
    chk("sat_err_pulses", err_pulses, 20);
    chk("sat_error_count", int'(error_count_o), 15);

    // Asynchronous reset mid-stream.
    drive(0, 1, 'h56);
    drive(0, 1, 'h57);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_locked", int'(locked_o), 0);
    chk("arst_error_count", int'(error_count_o), 0);
    chk("arst_wrap_count", int'(wrap_count_o), 0);
    chk("arst_expected", int'(expected_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 1, 'hfe);
    drive(0, 1, 'hff);
    drive(0, 1, 0);
    chk("arst_wrap_after", int'(wrap_count_o), 1);
    chk("arst_error_after", int'(error_count_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
